// File: rtl/la_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : la_pkg
//  Brief    : Shared types and helpers for the la_capture_core logic analyser
//  Revision : 1.0 - initial release
// ============================================================================
package la_pkg;

    // Capture FSM state codes; the numeric values are visible on state_o.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } la_state_e;

    // Widest probe bus supported; match operands are zero-extended to this.
    localparam int LA_MAX_DATA_W = 64;

    // Address width for a given buffer depth (never narrower than one bit).
    function automatic int la_addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Mask/value comparison: every masked channel must equal its value bit.
    // An all-zero mask therefore matches unconditionally.
    function automatic logic la_match(
        input logic [LA_MAX_DATA_W-1:0] data,
        input logic [LA_MAX_DATA_W-1:0] mask,
        input logic [LA_MAX_DATA_W-1:0] value
    );
        return ((data ^ value) & mask) == '0;
    endfunction

endpackage : la_pkg
`default_nettype wire

// File: rtl/la_sample_ram.sv
`default_nettype none
// ============================================================================
//  Module   : la_sample_ram
//  Brief    : Simple dual-port sample buffer, one write port and one
//             registered read port (block-RAM friendly coding)
//  Revision : 1.0 - initial release
// ============================================================================
module la_sample_ram
    import la_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = la_addr_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Storage array; contents are intentionally left uninitialised.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port: one sample per enabled cycle.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; the output register is cleared by reset so the
    // readout bus is deterministic while the core is held in reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule : la_sample_ram
`default_nettype wire

// File: rtl/la_capture_core.sv
`default_nettype none
// ============================================================================
//  Module   : la_capture_core
//  Brief    : Multi-channel logic-analyser capture engine. Samples DATA_W
//             probes into a circular buffer, keeps a programmable number of
//             pre-trigger samples and freezes once DEPTH samples surround the
//             trigger.
//  Revision : 1.0 - initial release
// ============================================================================
module la_capture_core
    import la_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = la_addr_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] trig_mask_i,
    input  logic [DATA_W-1:0] trig_value_i,
    input  logic              trig_edge_i,
    input  logic [AW-1:0]     pretrig_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [2:0]        state_o,
    output logic              triggered_o,
    output logic              done_o,
    output logic [AW-1:0]     trig_idx_o
);

    // Largest post-trigger count (pretrig = 0 leaves DEPTH-1 samples after).
    localparam logic [AW-1:0] POST_MAX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);

    la_state_e         state_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     fill_q;
    logic [AW-1:0]     post_q;
    logic [AW-1:0]     trig_wr_q;
    logic [AW-1:0]     start_q;
    logic [AW-1:0]     trig_idx_q;
    logic [AW-1:0]     pretrig_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] value_q;
    logic              edge_q;
    logic              prev_match_q;
    logic              triggered_q;
    logic              done_q;

    logic              arm_take;
    logic [DATA_W-1:0] eff_mask;
    logic [DATA_W-1:0] eff_value;
    logic              match;
    logic              hit;
    logic              wr_en;
    logic [AW-1:0]     fill_d;
    logic [AW-1:0]     post_d;
    logic [AW-1:0]     rd_phys;

    // abort has priority, so an arm in the same cycle is discarded.
    assign arm_take = arm_i & ~abort_i;

    // On the arm cycle the incoming trigger setup is already in force, so the
    // previous-match history seen by the first armed cycle uses the new setup.
    assign eff_mask  = arm_take ? trig_mask_i  : mask_q;
    assign eff_value = arm_take ? trig_value_i : value_q;

    assign match = la_match(LA_MAX_DATA_W'(data_i),
                            LA_MAX_DATA_W'(eff_mask),
                            LA_MAX_DATA_W'(eff_value));
    assign hit   = edge_q ? (match & ~prev_match_q) : match;

    // Samples are written only in the active capture states; a control pulse
    // takes the place of the write in its cycle.
    assign wr_en = ~arm_i & ~abort_i &
                   ((state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST));

    assign fill_d  = fill_q + ONE;
    assign post_d  = post_q - ONE;
    assign rd_phys = start_q + rd_addr_i;

    assign state_o     = state_q;
    assign triggered_o = triggered_q;
    assign done_o      = done_q;
    assign trig_idx_o  = trig_idx_q;

    // Capture FSM with its pointers, counters and registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            post_q       <= '0;
            trig_wr_q    <= '0;
            start_q      <= '0;
            trig_idx_q   <= '0;
            pretrig_q    <= '0;
            mask_q       <= '0;
            value_q      <= '0;
            edge_q       <= 1'b0;
            prev_match_q <= 1'b0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            prev_match_q <= match;
            if (abort_i) begin
                state_q     <= ST_IDLE;
                triggered_q <= 1'b0;
                done_q      <= 1'b0;
            end else if (arm_take) begin
                pretrig_q   <= pretrig_i;
                mask_q      <= trig_mask_i;
                value_q     <= trig_value_i;
                edge_q      <= trig_edge_i;
                wr_ptr_q    <= '0;
                fill_q      <= '0;
                triggered_q <= 1'b0;
                done_q      <= 1'b0;
                state_q     <= (pretrig_i == '0) ? ST_WAIT : ST_PRE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_PRE: begin
                        // Hits are ignored until the pre-trigger window is full.
                        wr_ptr_q <= wr_ptr_q + ONE;
                        fill_q   <= fill_d;
                        if (fill_d == pretrig_q) begin
                            state_q <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        wr_ptr_q <= wr_ptr_q + ONE;
                        if (hit) begin
                            trig_wr_q   <= wr_ptr_q;
                            triggered_q <= 1'b1;
                            post_q      <= POST_MAX - pretrig_q;
                            if (pretrig_q == POST_MAX) begin
                                // No post samples: the trigger write fills the buffer.
                                state_q    <= ST_DONE;
                                done_q     <= 1'b1;
                                start_q    <= wr_ptr_q - pretrig_q;
                                trig_idx_q <= pretrig_q;
                            end else begin
                                state_q <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        wr_ptr_q <= wr_ptr_q + ONE;
                        post_q   <= post_d;
                        if (post_q == ONE) begin
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            start_q    <= trig_wr_q - pretrig_q;
                            trig_idx_q <= pretrig_q;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_DONE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    la_sample_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_i),
        .raddr_i (rd_phys),
        .rdata_o (rd_data_o)
    );

endmodule : la_capture_core
`default_nettype wire

// File: doc/la_capture_core.md
Name: la_capture_core

Overview:
- Parametrised multi-channel capture engine; successor to the single-bit ao capture behind the GAO JTAG control path.
- Samples DATA_W probe channels every clk_i cycle into a circular buffer and evaluates a mask/value trigger, optionally edge-qualified.
- Keeps a programmable number of pre-trigger samples and freezes the buffer when full.
- Control and readout ports are driven by the JTAG control-register decoder.

Parameters:
- DATA_W, 8, number of probe channels sampled per cycle (1..64)
- DEPTH, 256, buffer depth in samples; power of two, 16..4096
- AW, $clog2(DEPTH), address width (derived; do not override)

Ports:
- clk_i  in  1  sample clock
- rst_i  in  1  reset; asynchronous, active-high
- data_i  in  DATA_W  probe channels
- arm_i  in  1  one-cycle pulse: start a new capture
- abort_i  in  1  one-cycle pulse: return to IDLE
- trig_mask_i  in  DATA_W  1 = channel participates in the trigger
- trig_value_i  in  DATA_W  required level per masked channel
- trig_edge_i  in  1  0 = level match; 1 = match must be new this cycle
- pretrig_i  in  AW  number of pre-trigger samples, 0..DEPTH-1
- rd_addr_i  in  AW  logical read index; 0 = oldest retained sample
- rd_data_o  out  DATA_W  sample at rd_addr_i
- state_o  out  3  current FSM state code
- triggered_o  out  1  trigger has fired in the current capture
- done_o  out  1  buffer frozen, readout valid
- trig_idx_o  out  AW  logical index of the trigger sample

Behaviour:
- Reset values:
  - state IDLE; all outputs 0; wr_ptr 0; fill counter 0; start pointer 0; previous-match register 0.
  - Buffer RAM contents are not reset.
- Match definition: match = ((data_i ^ trig_value_i) & trig_mask_i) == 0.
  - trig_edge_i = 1: hit = match & ~prev_match. prev_match is registered every cycle in every state.
  - trig_edge_i = 0: hit = match.
  - trig_mask_i = 0 gives match = 1 always. In edge mode it then never hits after the first armed cycle.
- State codes: IDLE = 0, PRE = 1, WAIT = 2, POST = 3, DONE = 4.
- IDLE:
  - No writes.
  - arm_i -> PRE; clear wr_ptr, fill counter, triggered_o and done_o.
- PRE:
  - Write data_i at wr_ptr each cycle, wr_ptr++, fill++.
  - When fill reaches pretrig_i, go to WAIT.
  - pretrig_i = 0 skips PRE: arm_i goes directly to WAIT.
  - Hits are ignored in PRE.
- WAIT:
  - Keep writing, wr_ptr wraps modulo DEPTH.
  - On a hit, the current sample is written and becomes the trigger sample:
    - trig_wr = wr_ptr; triggered_o = 1; post counter = DEPTH - 1 - pretrig_i; state -> POST.
    - If the post counter is 0, go directly to DONE instead.
- POST:
  - Write each cycle, post counter decrements.
  - When it reaches 0 after the final write, go to DONE.
  - Total samples retained = DEPTH.
- DONE:
  - No writes; done_o = 1.
  - start pointer = trig_wr - pretrig_i (mod DEPTH); trig_idx_o = pretrig_i.
  - Held until arm_i or abort_i.
- Readout:
  - Physical address = start pointer + rd_addr_i, modulo DEPTH.
  - rd_data_o is registered: valid 1 cycle after rd_addr_i.
  - Readout is only meaningful in DONE; outside DONE the read port still runs, data undefined.
- arm_i in any state restarts the capture: same actions as from IDLE, the previous capture is lost.
- abort_i -> IDLE, clears done_o and triggered_o.
  - abort_i and arm_i in the same cycle: abort_i wins.
- pretrig_i, trig_* and trig_edge_i are sampled on arm_i into internal registers. Changes mid-capture have no effect.
- Trigger sample latency: data_i is in the buffer at the edge where triggered_o rises.
- Reset asserted mid-capture: immediate IDLE, outputs cleared.

Decomposition:
- Package la_pkg:
  - state enum (IDLE/PRE/WAIT/POST/DONE, 3-bit);
  - DEPTH/AW helper function;
  - match function (data, mask, value).
- One sub-module, la_sample_ram:
  - simple dual-port RAM: write port and registered read port, DEPTH x DATA_W;
  - inferable as BSRAM.

Test Plan:
- Reset, then idle: all outputs 0, state_o = 0; arm never pulsed -> no writes.
- Basic capture:
  - Setup: DATA_W = 8, DEPTH = 16, pretrig = 4, counter ramp on data_i from 0, mask 0xFF, value 0x20, level mode.
  - Expected: done_o after the 11 post samples; reads idx 0..15 = 0x1C..0x2B; trig_idx_o = 4.
- Edge mode:
  - Setup: data_i held at 0x20 when armed, mask 0xFF, value 0x20.
  - Expected: no trigger until data_i leaves and returns to 0x20; trigger sample is the return cycle.
- Boundaries:
  - pretrig = 0 with mask = 0 (level): triggers on the first sample; idx 0 = first sample after arm.
  - pretrig = 15: DONE immediately after the trigger write.
- Wrap-around: wait 100 cycles before the trigger in WAIT -> readout contiguous and ordered across the physical wrap.
- Control overrides:
  - arm_i mid-POST restarts: triggered_o cleared, new data captured.
  - abort_i together with arm_i -> IDLE.
  - rst_i mid-capture -> state 0, all outputs 0.
